// File: rtl/apple_iie_video_scanner.sv
// Apple IIe video scan counters, blanking/sync decode and video RAM fetch address.
// Define VIDEO_SCANNER_PAL_EN for the 312-line frame (vertical start 9'h0C8); default is 262-line NTSC.
module apple_iie_video_scanner (
    input  logic        clk_14M,
    input  logic        reset_n,
    input  logic        cycle_en,
    input  logic        text_mode,
    input  logic        mixed_mode,
    input  logic        hires_mode,
    input  logic        page2,
    output logic [6:0]  h_count,
    output logic [8:0]  v_count,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic        long_cycle,
    output logic [15:0] video_a,
    output logic        video_a_valid,
    output logic        frame_start
);

`ifdef VIDEO_SCANNER_PAL_EN
    localparam logic [8:0] V_START = 9'h0C8;
`else
    localparam logic [8:0] V_START = 9'h0FA;
`endif

    logic [6:0]  h_count_reg, h_count_next;
    logic [8:0]  v_count_reg, v_count_next;
    logic        text_reg, mixed_reg, hires_reg, page2_reg;
    logic        frame_start_reg, frame_start_next;

    logic [6:0]  col;
    logic [7:0]  line;
    logic [4:0]  row;
    logic        use_gfx;
    logic [15:0] text_addr, hires_addr;

    // h_count state 0x00 is the long cycle; it jumps straight to 0x40
    always_comb begin
        h_count_next     = h_count_reg;
        v_count_next     = v_count_reg;
        frame_start_next = 1'b0;
        if (cycle_en) begin
            if (h_count_reg == 7'h00)
                h_count_next = 7'h40;
            else
                h_count_next = h_count_reg + 7'd1;
            if (h_count_reg == 7'h7F) begin
                if (v_count_reg == 9'h1FF) begin
                    v_count_next     = V_START;
                    frame_start_next = 1'b1;
                end else begin
                    v_count_next = v_count_reg + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_14M or negedge reset_n) begin
        if (!reset_n) begin
            h_count_reg     <= 7'h00;
            v_count_reg     <= V_START;
            text_reg        <= 1'b0;
            mixed_reg       <= 1'b0;
            hires_reg       <= 1'b0;
            page2_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            h_count_reg     <= h_count_next;
            v_count_reg     <= v_count_next;
            frame_start_reg <= frame_start_next;
            if (cycle_en) begin
                text_reg  <= text_mode;
                mixed_reg <= mixed_mode;
                hires_reg <= hires_mode;
                page2_reg <= page2;
            end
        end
    end

    // Display-relative coordinates; only meaningful while video_a_valid
    assign col  = h_count_reg - 7'h58;
    assign line = v_count_reg[7:0];
    assign row  = line[7:3];

    assign use_gfx = !text_reg && !(mixed_reg && (line >= 8'd160));

    // 0x28*k is built as 32*k + 8*k
    assign text_addr  = (page2_reg ? 16'h0800 : 16'h0400)
                      + {6'd0, row[2:0], 7'd0}
                      + {9'd0, row[4:3], 5'd0}
                      + {11'd0, row[4:3], 3'd0}
                      + {9'd0, col};
    assign hires_addr = (page2_reg ? 16'h4000 : 16'h2000)
                      + {3'd0, line[2:0], 10'd0}
                      + {6'd0, line[5:3], 7'd0}
                      + {9'd0, line[7:6], 5'd0}
                      + {11'd0, line[7:6], 3'd0}
                      + {9'd0, col};

    assign hblank        = (h_count_reg < 7'h58);
    assign vblank        = (v_count_reg[7:6] == 2'b11) || (v_count_reg < 9'h100);
    assign hsync         = (h_count_reg >= 7'h49) && (h_count_reg <= 7'h4C);
    assign vsync         = (v_count_reg >= 9'h1E0) && (v_count_reg <= 9'h1E3);
    assign long_cycle    = (h_count_reg == 7'h00);
    assign video_a_valid = !hblank && !vblank;

    always_comb begin
        video_a = 16'h0000;
        if (video_a_valid)
            video_a = (use_gfx && hires_reg) ? hires_addr : text_addr;
    end

    assign h_count     = h_count_reg;
    assign v_count     = v_count_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: doc/apple_iie_video_scanner.md
Name: apple_iie_video_scanner

Overview:
- Replaces the IOU/MMU video counter chain of the Apple IIe.
- Sits directly downstream of the timing generator: consumes a once-per-CPU-cycle strobe in the clk_14M domain.
- Produces the horizontal/vertical scan state, blanking, sync and long-cycle indications, plus the video RAM fetch address that the memory arbiter drives during phi_1.
- Feeds the memory arbiter and the future video shifter.

Parameters:
- none. Line count is selected by the optional feature below.

Ports:
- clk_14M  in  1  master 14.318 MHz clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cycle_en  in  1  one-clk_14M pulse at the end of each CPU cycle (phi_0 falling); the counters advance only on it
- text_mode  in  1  TEXT soft switch
- mixed_mode  in  1  MIXED soft switch
- hires_mode  in  1  HIRES soft switch
- page2  in  1  PAGE2 soft switch
- h_count  out  7  horizontal counter
- v_count  out  9  vertical counter
- hblank  out  1  horizontal blanking
- vblank  out  1  vertical blanking
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- long_cycle  out  1  current CPU cycle is the stretched 16-tick cycle
- video_a  out  16  video RAM fetch address
- video_a_valid  out  1  video_a is a displayed location
- frame_start  out  1  one-cycle pulse when a new frame begins

Behaviour:
- Reset (async on reset_n low):
  - h_count=7'h00, v_count=9'h0FA
  - mode register (text_mode, mixed_mode, hires_mode, page2 as sampled) = 0
  - frame_start=0
  - all decoded outputs follow from these values.
- Horizontal sequence, on each cycle_en:
  - h_count steps 0x00 -> 0x40 -> 0x41 ... 0x7F -> 0x00: 65 states per line.
  - Without cycle_en, all state holds.
- Vertical sequence:
  - v_count increments on the same cycle_en on which h_count wraps 0x7F -> 0x00.
  - v_count 0x1FF wraps to 0x0FA: 262 lines (NTSC).
- Mode register: loads all four soft-switch inputs on every cycle_en. Decodes use the registered copies, giving one CPU cycle of latency from switch to effect.
- Decodes (combinational from the registers):
  - hblank = (h_count < 7'h58).
  - vblank = (v_count[7:6] == 2'b11) or (v_count < 9'h100).
  - hsync = h_count in 0x49..0x4C.
  - vsync = v_count in 0x1E0..0x1E3.
  - long_cycle = (h_count == 7'h00).
- Active display: col = h_count - 0x58 (0..39); line = v_count - 0x100 (0..191); row = line>>3.
  - video_a_valid = !hblank && !vblank.
  - When not valid, video_a = 16'h0000.
- Graphics vs text selection: use_gfx = !text_mode && !(mixed_mode && line >= 160).
- Text/lores address (use_gfx=0, or hires_mode=0):
  - base = page2 ? 0x0800 : 0x0400
  - video_a = base + 0x80*(row mod 8) + 0x28*(row/8) + col.
- Hires address (use_gfx=1 and hires_mode=1):
  - base = page2 ? 0x4000 : 0x2000
  - video_a = base + 0x400*(line mod 8) + 0x80*((line/8) mod 8) + 0x28*(line/64) + col.
- Address arithmetic: unsigned, 16 bits, never overflows.
- frame_start: registered.
  - Set to 1 on the cycle_en on which v_count wraps to its start value.
  - Cleared on the next clk_14M edge.
- Simultaneous events:
  - A mode change on the same cycle_en as a line wrap takes effect on the first state of the new line.
  - Reset asserted mid-line returns to the reset values immediately; the first cycle_en after release moves h_count 0x00 -> 0x40.

Optional Feature:
- Macro: VIDEO_SCANNER_PAL_EN.
- Defined: v_count reset and wrap value is 9'h0C8, giving 312 lines; vertical blanking/sync decodes are unchanged.
- Undefined: 9'h0FA, giving 262 lines.

Test Plan:
- Release reset, pulse cycle_en 65 times -> h_count visits 0x00, then 0x40..0x7F, returns to 0x00; v_count 0x0FA -> 0x0FB; long_cycle=1 only at h_count 0x00.
- Run 262*65 cycle_en pulses from reset -> v_count back to 0x0FA; frame_start pulses exactly once for one clk_14M cycle.
- text_mode=1, page2=0, line 8 (v=0x108), first column (h=0x58) -> video_a=0x0480, valid=1; h=0x57 -> valid=0, video_a=0x0000.
- hires_mode=1, text_mode=0, page2=1, v=0x1BF, h=0x7F -> video_a=0x4000+0x1C00+0x380+0x50+39=0x5FF7.
- mixed_mode=1, hires, v=0x1A0 (line 160), h=0x58 -> text address 0x0650.
- With VIDEO_SCANNER_PAL_EN, run 312*65 pulses -> v_count wraps 0x1FF -> 0x0C8; assert reset_n low mid-line -> h_count=0x00 immediately, without waiting for a clock edge.
